fp_narrow_pack: RTL and testbench



---
 rtl/fp_narrow_pack.sv | 143 ++++++++++++++
 tb/tb_fp_narrow_pack.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_narrow_pack.sv
// Streaming FP narrowing converter (RNE) that packs PACK narrow results per output beat.
// Optional: define FP_NARROW_SAT_EN to saturate overflow to max finite instead of inf.
module fp_narrow_pack #(
  parameter int EXP_IN  = 8,
  parameter int MAN_IN  = 23,
  parameter int EXP_OUT = 5,
  parameter int MAN_OUT = 10,
  parameter int PACK    = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic [EXP_IN+MAN_IN:0]        in_data_i,
  input  logic                          in_last_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [PACK*(EXP_OUT+MAN_OUT+1)-1:0] out_data_o,
  output logic [PACK-1:0]               out_keep_o,
  output logic [3:0]                    out_flags_o
);
  localparam int WIDTH_IN  = 1 + EXP_IN + MAN_IN;
  localparam int WIDTH_OUT = 1 + EXP_OUT + MAN_OUT;
  localparam int BIAS_IN   = (1 << (EXP_IN - 1)) - 1;
  localparam int BIAS_OUT  = (1 << (EXP_OUT - 1)) - 1;
  localparam int EW = EXP_IN + 2;
  localparam int XW = MAN_IN + 1 + MAN_OUT + 2;
  localparam int SW = $clog2(MAN_OUT + 3);
  localparam int CW = (PACK > 1) ? $clog2(PACK) : 1;
  localparam logic signed [EW-1:0] E_ONE  = EW'(1);
  localparam logic signed [EW-1:0] E_MAX  = EW'((1 << EXP_OUT) - 1);
  localparam logic signed [EW-1:0] E_TINY = EW'(-(MAN_OUT + 1));
  localparam logic [EW-1:0]        REBIAS = EW'(BIAS_IN - BIAS_OUT);

  logic                  sgn;
  logic [EXP_IN-1:0]     exp_in;
  logic [MAN_IN-1:0]     man_in;
  logic signed [EW-1:0]  e, e_rnd;
  logic [SW-1:0]         sh;
  logic [XW-1:0]         ext;
  logic [MAN_OUT:0]      top;
  logic                  guard, sticky, rup;
  logic [MAN_OUT+1:0]    rnd;
  logic [WIDTH_OUT-1:0]  conv;
  logic [3:0]            conv_flags;

  assign {sgn, exp_in, man_in} = in_data_i[WIDTH_IN-1:0];

  // Normal and subnormal results share one datapath: subnormals are the hidden-1
  // significand right-shifted by 1-e, capped so the hidden bit lands in sticky.
  always_comb begin
    e = $signed({2'b00, exp_in} - REBIAS);
    if (e >= E_ONE)       sh = '0;
    else if (e < E_TINY)  sh = SW'(MAN_OUT + 2);
    else                  sh = SW'(E_ONE - e);
    ext    = {1'b1, man_in, {(MAN_OUT+2){1'b0}}} >> sh;
    top    = ext[XW-1 -: MAN_OUT+1];
    guard  = ext[XW-MAN_OUT-2];
    sticky = |ext[XW-MAN_OUT-3:0];
    rup    = guard & (sticky | top[0]);
    rnd    = {1'b0, top} + {{(MAN_OUT+1){1'b0}}, rup};
    e_rnd  = e + EW'(rnd[MAN_OUT+1]);
    conv       = '0;
    conv_flags = '0;
    if (exp_in == '1) begin
      if (man_in != '0) begin
        conv          = {1'b0, {EXP_OUT{1'b1}}, 1'b1, {(MAN_OUT-1){1'b0}}};
        conv_flags[3] = ~man_in[MAN_IN-1];
      end else begin
        conv = {sgn, {EXP_OUT{1'b1}}, {MAN_OUT{1'b0}}};
      end
    end else if (exp_in == '0) begin
      conv = {sgn, {(WIDTH_OUT-1){1'b0}}};
      if (man_in != '0) conv_flags = 4'b0011;
    end else if (e >= E_ONE && e_rnd >= E_MAX) begin
      conv_flags = 4'b0101;
`ifdef FP_NARROW_SAT_EN
      conv = {sgn, EXP_OUT'((1 << EXP_OUT) - 2), {MAN_OUT{1'b1}}};
`else
      conv = {sgn, {EXP_OUT{1'b1}}, {MAN_OUT{1'b0}}};
`endif
    end else if (e >= E_ONE) begin
      conv          = {sgn, e_rnd[EXP_OUT-1:0], rnd[MAN_OUT-1:0]};
      conv_flags[0] = guard | sticky;
    end else begin
      // rnd[MAN_OUT] set means rounding reached min normal, i.e. exp field 1
      conv          = {sgn, {(EXP_OUT-1){1'b0}}, rnd[MAN_OUT], rnd[MAN_OUT-1:0]};
      conv_flags[1] = 1'b1;
      conv_flags[0] = guard | sticky;
    end
  end

  typedef logic [PACK-1:0][WIDTH_OUT-1:0] lanes_t;
  lanes_t          lanes_q, lanes_d;
  logic [PACK-1:0] keep_q, keep_d;
  logic [3:0]      flags_q, flags_d;
  logic [CW-1:0]   cnt_q, cnt_d, idx;
  logic            valid_q, valid_d, accept, drain, close;

  assign in_ready_o = ~rst_i & (~valid_q | out_ready_i);
  assign accept     = in_valid_i & in_ready_o;
  assign drain      = valid_q & out_ready_i;
  // a word accepted during the emit handshake opens the next beat at lane 0
  assign idx        = valid_q ? '0 : cnt_q;

  always_comb begin
    lanes_d = drain ? '0 : lanes_q;
    keep_d  = drain ? '0 : keep_q;
    flags_d = drain ? '0 : flags_q;
    cnt_d   = drain ? '0 : cnt_q;
    valid_d = valid_q & ~out_ready_i;
    close   = 1'b0;
    if (accept) begin
      lanes_d[idx] = conv;
      keep_d[idx]  = 1'b1;
      flags_d      = flags_d | conv_flags;
      close        = in_last_i | (idx == CW'(PACK - 1));
      valid_d      = close;
      cnt_d        = close ? '0 : idx + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lanes_q <= '0;
      keep_q  <= '0;
      flags_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      lanes_q <= lanes_d;
      keep_q  <= keep_d;
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = lanes_q;
  assign out_keep_o  = keep_q;
  assign out_flags_o = flags_q;
endmodule

// File: tb/tb_fp_narrow_pack.sv
// Bench for fp_narrow_pack (FP32->FP16, PACK=4): directed vectors plus random traffic vs a value-level model.
module tb_fp_narrow_pack;
  logic        clk_i = 1'b0;
  logic        rst_i, in_valid_i, in_ready_o, in_last_i, out_valid_o, out_ready_i;
  logic [31:0] in_data_i;
  logic [63:0] out_data_o;
  logic [3:0]  out_keep_o, out_flags_o;
  int          checks = 0, errors = 0;

`ifdef FP_NARROW_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  localparam logic [15:0] OVF_P = SAT ? 16'h7BFF : 16'h7C00;
  localparam logic [15:0] OVF_N = SAT ? 16'hFBFF : 16'hFC00;

  always #5 clk_i = ~clk_i;

  fp_narrow_pack #(.EXP_IN(8), .MAN_IN(23), .EXP_OUT(5), .MAN_OUT(10), .PACK(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_data_i(in_data_i), .in_last_i(in_last_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .out_data_o(out_data_o), .out_keep_o(out_keep_o),
    .out_flags_o(out_flags_o));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Value-level reference: result = round(x / quantum) * quantum, quantum = 2^(max(ue,-14)-10).
  function automatic logic [19:0] ref_conv(input logic [31:0] w);
    logic   s, nx, uf;
    int     ue, qe, k, ex;
    longint sig, q, rem, half;
    s = w[31];
    if (w[30:23] == 8'hFF)
      return (w[22:0] != 0) ? {~w[22], 3'b000, 16'h7E00} : {4'b0000, s, 15'h7C00};
    if (w[30:23] == 8'h00)
      return (w[22:0] != 0) ? {4'b0011, s, 15'h0000} : {4'b0000, s, 15'h0000};
    sig = longint'({1'b1, w[22:0]});
    ue  = int'(w[30:23]) - 127;
    qe  = ((ue < -14) ? -14 : ue) - 10;
    k   = qe - (ue - 23);
    if (k >= 40) begin
      q = 0; rem = sig; half = longint'(1) << 39;
    end else begin
      q = sig >> k; rem = sig - (q << k); half = longint'(1) << (k - 1);
    end
    if (rem > half || (rem == half && q[0])) q++;
    nx = (rem != 0);
    uf = (ue < -14);
    if (q == 2048) begin q = 1024; qe++; end
    if (q < 1024) return {2'b00, uf, nx, s, 5'd0, q[9:0]};
    ex = qe + 25;
    if (ex >= 31) return {4'b0101, s, SAT ? 15'h7BFF : 15'h7C00};
    return {2'b00, uf, nx, s, ex[4:0], q[9:0]};
  endfunction

  function automatic logic [31:0] rand_word();
    logic [7:0]  e;
    logic [22:0] m;
    m = 23'($urandom());
    case ($urandom_range(0, 7))
      0, 1, 2, 3: e = 8'($urandom_range(96, 145));
      4:          e = 8'($urandom_range(140, 143));
      5:          e = 8'($urandom_range(1, 254));
      6:          e = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
      default:    e = 8'($urandom_range(100, 114));
    endcase
    if ($urandom_range(0, 3) == 0) m[11:0] = '0;
    return {1'($urandom()), e, m};
  endfunction

  // Scoreboard: accepted words are grouped into expected beats; every drained beat is compared.
  typedef struct { logic [63:0] d; logic [3:0] k; logic [3:0] f; } beat_t;
  beat_t       exp_q[$];
  beat_t       mb;
  logic [63:0] p_d, hold_d;
  logic [3:0]  p_k, p_f;
  logic [19:0] mr;
  int          p_n;
  logic        hold;

  always @(negedge clk_i) begin
    if (rst_i) begin
      exp_q.delete();
      p_d = '0; p_k = '0; p_f = '0; p_n = 0; hold = 1'b0;
    end else begin
      if (hold) begin
        chk("hold_valid", 64'(out_valid_o), 64'd1);
        chk("hold_data", out_data_o, hold_d);
      end
      hold   = out_valid_o & ~out_ready_i;
      hold_d = out_data_o;
      if (out_valid_o && out_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL beat_unexpected: got %h expected no beat", out_data_o);
        end else begin
          mb = exp_q.pop_front();
          chk("beat_data", out_data_o, mb.d);
          chk("beat_keep_flags", 64'({out_keep_o, out_flags_o}), 64'({mb.k, mb.f}));
        end
      end
      if (in_valid_i && in_ready_o) begin
        mr = ref_conv(in_data_i);
        p_d[p_n*16 +: 16] = mr[15:0];
        p_k[p_n] = 1'b1;
        p_f = p_f | mr[19:16];
        p_n++;
        if (p_n == 4 || in_last_i) begin
          exp_q.push_back('{p_d, p_k, p_f});
          p_d = '0; p_k = '0; p_f = '0; p_n = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic send(input logic [31:0] w, input logic l);
    bit acc = 1'b0;
    in_valid_i = 1'b1; in_data_i = w; in_last_i = l;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge clk_i);
      acc = in_ready_o;
      tick();
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL send_timeout: got in_ready 0 for 200 cycles expected acceptance of %h", w);
    end
    in_valid_i = 1'b0; in_last_i = 1'b0;
  endtask

  typedef struct { logic [31:0] w; logic [15:0] h; logic [3:0] f; } vec_t;
  vec_t vecs[16];

  localparam logic [63:0] BASIC = 64'h7BFF_B800_4000_3C00;

  task automatic send_basic();
    send(32'h3F800000, 1'b0);
    send(32'h40000000, 1'b0);
    send(32'hBF000000, 1'b0);
    send(32'h477FE000, 1'b0);
  endtask

  initial begin
    vecs[0]  = '{32'h3F800000, 16'h3C00, 4'h0};
    vecs[1]  = '{32'h3F801000, 16'h3C00, 4'h1};
    vecs[2]  = '{32'h3F803000, 16'h3C02, 4'h1};
    vecs[3]  = '{32'h33800000, 16'h0001, 4'h2};
    vecs[4]  = '{32'h32800000, 16'h0000, 4'h3};
    vecs[5]  = '{32'h7F800001, 16'h7E00, 4'h8};
    vecs[6]  = '{32'hFF800000, 16'hFC00, 4'h0};
    vecs[7]  = '{32'h4788B800, OVF_P,    4'h5};
    vecs[8]  = '{32'hC788B800, OVF_N,    4'h5};
    vecs[9]  = '{32'h477FF000, OVF_P,    4'h5};
    vecs[10] = '{32'h387FE000, 16'h0400, 4'h3};
    vecs[11] = '{32'h38000000, 16'h0200, 4'h2};
    vecs[12] = '{32'h80400000, 16'h8000, 4'h3};
    vecs[13] = '{32'h7FC00000, 16'h7E00, 4'h0};
    vecs[14] = '{32'h80000000, 16'h8000, 4'h0};
    vecs[15] = '{32'h477FE000, 16'h7BFF, 4'h0};

    rst_i = 1'b1; in_valid_i = 1'b1; in_data_i = 32'h3F800000; in_last_i = 1'b0; out_ready_i = 1'b1;
    repeat (3) tick();
    @(negedge clk_i);
    chk("reset_ready", 64'(in_ready_o), 64'd0);
    chk("reset_outs", {out_data_o[59:0], out_valid_o, out_keep_o[2:0]}, 64'd0);
    chk("reset_keep_flags", 64'({out_keep_o, out_flags_o}), 64'd0);
    tick();
    in_valid_i = 1'b0; rst_i = 1'b0;
    tick();

    // basic pack, valid exactly one cycle after the 4th accept
    send_basic();
    chk("pack_valid", 64'(out_valid_o), 64'd1);
    chk("pack_data", out_data_o, BASIC);
    chk("pack_keep_flags", 64'({out_keep_o, out_flags_o}), 64'({4'b1111, 4'h0}));
    tick();
    chk("pack_drained", 64'(out_valid_o), 64'd0);

    for (int i = 0; i < 16; i++) begin
      send(vecs[i].w, 1'b1);
      chk($sformatf("vec%0d_ctl", i), 64'({out_valid_o, out_keep_o, out_flags_o}),
          64'({1'b1, 4'b0001, vecs[i].f}));
      chk($sformatf("vec%0d_data", i), out_data_o, {48'h0, vecs[i].h});
      tick();
    end

    // backpressure: beat 1 held, 5th word stalls, then joins beat 2 during the drain handshake
    out_ready_i = 1'b0;
    send_basic();
    in_valid_i = 1'b1; in_data_i = 32'h3F801000; in_last_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk("bp_stall_ready", 64'(in_ready_o), 64'd0);
      chk("bp_stall_data", {out_data_o}, BASIC);
      tick();
    end
    out_ready_i = 1'b1;
    @(negedge clk_i);
    chk("bp_ready_follows", 64'(in_ready_o), 64'd1);
    tick();
    in_valid_i = 1'b0;
    chk("bp_after_drain", 64'({out_valid_o, out_keep_o}), 64'({1'b0, 4'b0001}));
    send(32'h3F803000, 1'b1);
    chk("bp_beat2_ctl", 64'({out_valid_o, out_keep_o, out_flags_o}), 64'({1'b1, 4'b0011, 4'h1}));
    chk("bp_beat2_data", out_data_o, 64'h0000_0000_3C02_3C00);
    tick();

    // reset in the middle of a beat discards the partial lanes
    send(32'h40000000, 1'b0);
    send(32'h40000000, 1'b0);
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("midrst_ready", 64'(in_ready_o), 64'd0);
    tick();
    rst_i = 1'b0;
    chk("midrst_cleared", {out_data_o[59:0], out_valid_o, out_keep_o[2:0]}, 64'd0);
    send_basic();
    chk("midrst_fresh", out_data_o, BASIC);
    chk("midrst_keep", 64'({out_valid_o, out_keep_o}), 64'({1'b1, 4'b1111}));
    tick();

    for (int c = 0; c < 3000; c++) begin
      in_valid_i  = ($urandom_range(0, 3) != 0);
      in_data_i   = rand_word();
      in_last_i   = ($urandom_range(0, 5) == 0);
      out_ready_i = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid_i = 1'b0; in_last_i = 1'b0; out_ready_i = 1'b1;
    repeat (5) tick();
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
